sram_dp: RTL and testbench
==========================

# sram_dp

Parametrised dual-port synchronous SRAM with byte-lane writes. Port A reads and writes; port B is read-only. Adds four things to the fixed 8K×32 single-mode array:
- sequential clear-on-reset FSM;
- selectable port-A read-during-write mode;
- port-B byte-merged write forwarding;
- optional output register stage with valid flags.

It is the core's instruction/data scratch memory: port A serves load/store, port B serves fetch.

## Interface
- ADDR_W, 13, word address width; DEPTH = 2**ADDR_W
- DATA_W, 32, word width; multiple of 8; NB = DATA_W/8 lanes
- OUT_REG, 0, 1 = extra output register stage
- WR_FIRST, 0, port-A same-address read during write: 0 returns old word, 1 returns merged new word
- CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset
- INIT_VAL, 0, fill value used by the clear FSM

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- addr  in  ADDR_W  port-A address
- byteen  in  NB  port-A write lane enables; lane i = data[8i+7:8i]
- data  in  DATA_W  port-A write data
- wren  in  1  port-A write strobe
- rden  in  1  port-A read strobe
- q  out  DATA_W  port-A read data
- q_valid  out  1  q carries a new result this cycle
- addr2  in  ADDR_W  port-B address
- rden2  in  1  port-B read strobe
- q2  out  DATA_W  port-B read data
- q2_valid  out  1  q2 carries a new result this cycle
- busy  out  1  clear in progress; all requests ignored

## Operation
- FSM states: CLEAR and RUN.
- rst_n low: state ← CLEAR if CLEAR_ON_RESET, else RUN; clr_cnt ← 0.
- CLEAR:
  - each cycle writes INIT_VAL to mem[clr_cnt], then clr_cnt++;
  - after writing DEPTH-1 → RUN;
  - busy = (state == CLEAR).
- Reset asserted mid-clear: restart from clr_cnt = 0. Reset never clears the array directly.
- Requests while busy: wren, rden and rden2 are dropped. No array update, no valid pulse.
- Port-A write (RUN, wren): for each i with byteen[i]=1, mem[addr] lane i ← data lane i. Other lanes unchanged. byteen=0 is a no-op write.
- Port-A read (RUN, rden): samples mem[addr].
  - wren and rden same cycle, WR_FIRST=0: old word.
  - wren and rden same cycle, WR_FIRST=1: per lane, byteen[i] ? data lane : old lane.
- Port-B read (RUN, rden2): samples mem[addr2].
  - If a port-A write to addr2 occurs the same cycle: byte-merged new word (forwarding), independent of WR_FIRST.
- q and q2 hold their last value when no read completes. Valids are single-cycle pulses per completed read.

## Timing
- Reset values: q=0, q2=0, q_valid=0, q2_valid=0, busy=1 (CLEAR_ON_RESET=1) else 0.
- Clear duration: exactly DEPTH cycles after the first clk edge with rst_n high; busy falls on edge DEPTH.
- Read latency, request edge to data:
  - OUT_REG=0: 1 cycle; q and q_valid update on the edge that samples rden.
  - OUT_REG=1: 2 cycles.
- Throughput: one read per port per cycle. Back-to-back reads are fully pipelined.
- Write visibility: a write at edge N is visible to any read sampled at edge N+1.
- A read at edge N to the same address follows the same-cycle rules above.
- Address wrap: addresses are full ADDR_W; no out-of-range case exists.
- Reset mid-pipeline: the OUT_REG stage and valids clear to 0; in-flight reads are discarded.

## Structure
- Package sram_pkg: FSM state enum (ST_CLEAR, ST_RUN) and the byte-merge function merge(old, new, be).
- Sub-module sram_dp_array: raw storage, one byte-enabled write port, two synchronous read ports, no reset; must infer as block RAM.
- sram_dp holds the clear FSM and counter, write-port mux (clear vs. port A), forwarding comparators, and the optional output stage.

## Test plan
- Clear: CLEAR_ON_RESET=1, ADDR_W=4.
  - busy=1 for exactly 16 cycles.
  - Then read 0..15 → all 00000000.
  - wren during busy at addr 3 with 0xffffffff is dropped: addr 3 still reads 00000000.
- Byte lanes:
  - write 0 be=1111 0x12345678;
  - write 0 be=1100 0x9876dead → read 98765678;
  - write 0 be=0011 0xdead5432 → read 98765432;
  - write be=0000 → unchanged.
- Read-during-write on port A, addr 5 holding 0x11111111, write be=0101 0xaabbccdd same cycle:
  - WR_FIRST=0: q=11111111;
  - WR_FIRST=1: q=11bb11dd;
  - next cycle both modes read 11bb11dd.
- Port-B forwarding: same write as above with rden2, addr2=5 → q2=11bb11dd. With addr2=6 → old mem[6].
- Latency: OUT_REG=0 and OUT_REG=1, streaming reads 0,1,2 on both ports.
  - q_valid/q2_valid pulses appear exactly 1 or 2 cycles after each request.
  - q holds its value when rden=0.
- Reset mid-clear: assert rst_n=0 at clr_cnt=7 with ADDR_W=4.
  - busy stays high for a further full 16 cycles after release.
  - Pipeline valids are 0 during reset.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_dp shared types: clear FSM state and lane merge helper.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  function automatic logic [7:0] merge(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_dp_array.sv
// Raw dual-read storage: one byte-enabled write port, two sync reads.
module sram_dp_array #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wbe,
  input  logic                  i_rea,
  input  logic [ADDR_W-1:0]     i_addra,
  output logic [DATA_W-1:0]     o_qa,
  input  logic                  i_reb,
  input  logic [ADDR_W-1:0]     i_addrb,
  output logic [DATA_W-1:0]     o_qb
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_qa;
  logic [DATA_W-1:0] r_qb;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (i_we && i_wbe[i])
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  // Read-first: reads return the word before this edge's write.
  always_ff @(posedge clk) begin
    if (i_rea) r_qa <= r_mem[i_addra];
  end

  always_ff @(posedge clk) begin
    if (i_reb) r_qb <= r_mem[i_addrb];
  end

  assign o_qa = r_qa;
  assign o_qb = r_qb;

endmodule

// File: rtl/sram_dp.sv
// Dual-port scratch SRAM: clear FSM, RDW mode, B-port forwarding.
module sram_dp
  import sram_pkg::*;
#(
  parameter int              ADDR_W         = 13,
  parameter int              DATA_W         = 32,
  parameter int              OUT_REG        = 0,
  parameter int              WR_FIRST       = 0,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] byteen,
  input  logic [DATA_W-1:0]   data,
  input  logic                wren,
  input  logic                rden,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  input  logic [ADDR_W-1:0]   addr2,
  input  logic                rden2,
  output logic [DATA_W-1:0]   q2,
  output logic                q2_valid,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_cnt;
    unique case (r_state)
      ST_CLEAR: begin
        w_clr_nxt = r_clr_cnt + ADDR_W'(1);
        if (&r_clr_cnt) w_state_nxt = ST_RUN;
      end
      ST_RUN: ;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  logic              w_run;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_wbe;
  logic              w_rda;
  logic              w_rdb;
  logic              w_fwda;
  logic              w_fwdb;

  assign w_run   = (r_state == ST_RUN);
  assign busy    = (r_state == ST_CLEAR);
  assign w_we    = rst_n & (w_run ? wren : 1'b1);
  assign w_waddr = w_run ? addr   : r_clr_cnt;
  assign w_wdata = w_run ? data   : INIT_VAL;
  assign w_wbe   = w_run ? byteen : '1;
  assign w_rda   = w_run & rden;
  assign w_rdb   = w_run & rden2;
  assign w_fwda  = (WR_FIRST != 0) & wren;
  assign w_fwdb  = wren & (addr2 == addr);

  logic [DATA_W-1:0] w_arr_qa;
  logic [DATA_W-1:0] w_arr_qb;

  sram_dp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_wbe   (w_wbe),
    .i_rea   (w_rda),
    .i_addra (addr),
    .o_qa    (w_arr_qa),
    .i_reb   (w_rdb),
    .i_addrb (addr2),
    .o_qb    (w_arr_qb)
  );

  // Forwarded write lanes are held and merged over the array's old word.
  logic              r_va, r_vb;
  logic              r_oka, r_okb;
  logic              r_fa, r_fb;
  logic [DATA_W-1:0] r_fda, r_fdb;
  logic [NB-1:0]     r_fbea, r_fbeb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_va   <= 1'b0;
      r_vb   <= 1'b0;
      r_oka  <= 1'b0;
      r_okb  <= 1'b0;
      r_fa   <= 1'b0;
      r_fb   <= 1'b0;
      r_fda  <= '0;
      r_fdb  <= '0;
      r_fbea <= '0;
      r_fbeb <= '0;
    end else begin
      r_va <= w_rda;
      r_vb <= w_rdb;
      if (w_rda) begin
        r_oka <= 1'b1;
        r_fa  <= w_fwda;
      end
      if (w_rdb) begin
        r_okb <= 1'b1;
        r_fb  <= w_fwdb;
      end
      if (w_rda && w_fwda) begin
        r_fda  <= data;
        r_fbea <= byteen;
      end
      if (w_rdb && w_fwdb) begin
        r_fdb  <= data;
        r_fbeb <= byteen;
      end
    end
  end

  logic [DATA_W-1:0] w_qa, w_qb;
  logic [DATA_W-1:0] w_q1a, w_q1b;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign w_qa[8*i +: 8] = merge(w_arr_qa[8*i +: 8],
                                  r_fda[8*i +: 8],
                                  r_fa & r_fbea[i]);
    assign w_qb[8*i +: 8] = merge(w_arr_qb[8*i +: 8],
                                  r_fdb[8*i +: 8],
                                  r_fb & r_fbeb[i]);
  end

  assign w_q1a = r_oka ? w_qa : '0;
  assign w_q1b = r_okb ? w_qb : '0;

  if (OUT_REG != 0) begin : g_oreg
    logic              r_qa_o, r_qb_o;
    logic [DATA_W-1:0] r_da_o, r_db_o;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_qa_o <= 1'b0;
        r_qb_o <= 1'b0;
        r_da_o <= '0;
        r_db_o <= '0;
      end else begin
        r_qa_o <= r_va;
        r_qb_o <= r_vb;
        if (r_va) r_da_o <= w_q1a;
        if (r_vb) r_db_o <= w_q1b;
      end
    end

    assign q        = r_da_o;
    assign q_valid  = r_qa_o;
    assign q2       = r_db_o;
    assign q2_valid = r_qb_o;
  end else begin : g_noreg
    assign q        = w_q1a;
    assign q_valid  = r_va;
    assign q2       = w_q1b;
    assign q2_valid = r_vb;
  end

endmodule

// File: tb/tb_sram_dp.sv
// Directed bench: two sram_dp instances (comb/old-word, reg/new-word).
module tb_sram_dp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr, addr2;
  logic [3:0]  byteen;
  logic [31:0] data;
  logic        wren, rden, rden2;

  logic [31:0] q0, q20, q1, q21;
  logic        qv0, q2v0, qv1, q2v1;
  logic        busy0, busy1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_dp #(
    .ADDR_W(4), .DATA_W(32), .OUT_REG(0),
    .WR_FIRST(0), .CLEAR_ON_RESET(1), .INIT_VAL(32'h0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .byteen(byteen),
    .data(data), .wren(wren), .rden(rden), .q(q0),
    .q_valid(qv0), .addr2(addr2), .rden2(rden2), .q2(q20),
    .q2_valid(q2v0), .busy(busy0)
  );

  sram_dp #(
    .ADDR_W(4), .DATA_W(32), .OUT_REG(1),
    .WR_FIRST(1), .CLEAR_ON_RESET(1), .INIT_VAL(32'h0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .byteen(byteen),
    .data(data), .wren(wren), .rden(rden), .q(q1),
    .q_valid(qv1), .addr2(addr2), .rden2(rden2), .q2(q21),
    .q2_valid(q2v1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wren   = 1'b0;
    rden   = 1'b0;
    rden2  = 1'b0;
    byteen = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    addr = a; data = d; byteen = be; wren = 1'b1;
    step;
    idle;
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] e);
    addr = a; addr2 = a; rden = 1'b1; rden2 = 1'b1;
    step;
    idle;
    chk({tag, "_q0"}, q0, e);
    chk({tag, "_q20"}, q20, e);
    chk({tag, "_v0"}, 32'({qv0, q2v0, qv1}), 32'b110);
    step;
    chk({tag, "_q1"}, q1, e);
    chk({tag, "_q21"}, q21, e);
    chk({tag, "_v1"}, 32'({qv0, qv1, q2v1}), 32'b011);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    int vs = 0;
    while (busy0 && n < 40) begin
      step;
      n++;
      if (qv0 | q2v0 | qv1 | q2v1) vs++;
    end
    idle;
    chk({tag, "_len"}, 32'(n), 32'd16);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
    chk({tag, "_nov"}, 32'(vs), 32'd0);
  endtask

  logic [31:0] rv [3];
  int ka, kb;

  initial begin
    rst_n = 1'b0;
    addr = 4'h0; addr2 = 4'h0; data = 32'h0;
    idle;
    repeat (3) step;
    chk("rst_q", {q0[15:0], q1[15:0]}, 32'h0);
    chk("rst_q2", q20 | q21, 32'h0);
    chk("rst_v", 32'({qv0, q2v0, qv1, q2v1}), 32'h0);
    chk("rst_busy", 32'({busy0, busy1}), 32'b11);

    // Requests during clear must be dropped.
    rst_n = 1'b1;
    addr = 4'd3; addr2 = 4'd3; data = 32'hffffffff;
    byteen = 4'hf; wren = 1'b1; rden = 1'b1; rden2 = 1'b1;
    wait_clear("clr");

    for (int i = 0; i < 16; i++) begin
      addr = 4'(i); addr2 = 4'(15 - i); rden = 1'b1; rden2 = 1'b1;
      step;
      chk("clr_q0", q0, 32'h0);
      chk("clr_q20", q20, 32'h0);
    end
    idle;
    step;
    rd("clr_a3", 4'd3, 32'h0);

    wr(4'd0, 32'h12345678, 4'b1111);
    wr(4'd0, 32'h9876dead, 4'b1100);
    rd("be_hi", 4'd0, 32'h98765678);
    wr(4'd0, 32'hdead5432, 4'b0011);
    rd("be_lo", 4'd0, 32'h98765432);
    wr(4'd0, 32'hffffffff, 4'b0000);
    rd("be_none", 4'd0, 32'h98765432);

    wr(4'd5, 32'h11111111, 4'hf);
    wr(4'd6, 32'h66666666, 4'hf);
    addr = 4'd5; addr2 = 4'd5; data = 32'haabbccdd;
    byteen = 4'b0101; wren = 1'b1; rden = 1'b1; rden2 = 1'b1;
    step;
    idle;
    chk("rdw_old_q0", q0, 32'h11111111);
    chk("fwd_q20", q20, 32'h11bb11dd);
    step;
    chk("rdw_new_q1", q1, 32'h11bb11dd);
    chk("fwd_q21", q21, 32'h11bb11dd);
    rd("rdw_next", 4'd5, 32'h11bb11dd);

    addr = 4'd5; addr2 = 4'd6; data = 32'h22334455;
    byteen = 4'b0101; wren = 1'b1; rden2 = 1'b1;
    step;
    idle;
    chk("nofwd_q20", q20, 32'h66666666);
    step;
    chk("nofwd_q21", q21, 32'h66666666);
    rd("rdw2", 4'd5, 32'h11331155);

    // Streaming: A reads 0,1,2 while B reads 2,1,0.
    rv[0] = 32'ha0a0a0a0;
    rv[1] = 32'hb1b1b1b1;
    rv[2] = 32'hc2c2c2c2;
    for (int i = 0; i < 3; i++) wr(4'(i), rv[i], 4'hf);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        addr = 4'(k); addr2 = 4'(2 - k);
        rden = 1'b1; rden2 = 1'b1;
      end else begin
        idle;
      end
      step;
      ka = (k < 2) ? k : 2;
      chk("s_q0", q0, rv[ka]);
      chk("s_q20", q20, rv[2-ka]);
      chk("s_v0", 32'({qv0, q2v0}), (k < 3) ? 32'b11 : 32'b00);
      chk("s_v1", 32'({qv1, q2v1}),
          (k >= 1 && k <= 3) ? 32'b11 : 32'b00);
      if (k >= 1) begin
        kb = (k - 1 < 2) ? k - 1 : 2;
        chk("s_q1", q1, rv[kb]);
        chk("s_q21", q21, rv[2-kb]);
      end
    end

    // Reset with a read in flight, then reset again mid-clear.
    addr = 4'd5; addr2 = 4'd5; rden = 1'b1; rden2 = 1'b1;
    step;
    rst_n = 1'b0;
    idle;
    step;
    chk("mrst_v", 32'({qv0, q2v0, qv1, q2v1}), 32'h0);
    chk("mrst_q1", q1 | q21, 32'h0);
    chk("mrst_q0", q0 | q20, 32'h0);
    step;
    rst_n = 1'b1;
    repeat (7) step;
    rst_n = 1'b0;
    step;
    chk("mclr_v", 32'({qv0, q2v0, qv1, q2v1}), 32'h0);
    step;
    chk("mclr_busy", 32'({busy0, busy1}), 32'b11);
    rst_n = 1'b1;
    wait_clear("mclr");
    rd("mclr_a5", 4'd5, 32'h0);
    rd("mclr_a0", 4'd0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", 0, 1);
    $fatal(1);
  end

endmodule
